// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, flag bit positions,
// controller states and the common flag-packing helper.
package alu_multicycle_pkg;

    localparam int WIDTH    = 16;
    localparam int ITER_CNT = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_MOD = 4'd10;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ITER,
        S_DONE
    } state_t;

    function automatic logic [3:0] makeFlags(input logic [WIDTH-1:0] r,
                                             input logic c,
                                             input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the controller and the ALU.
interface alu_multicycle_if;
    import alu_multicycle_pkg::*;

    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;
    logic [3:0]       ALU_flags;
    logic             ALU_ready;
    logic             busy;

    modport master (
        output start, opcode, operand_a, operand_b,
        input  result, ALU_flags, ALU_ready, busy
    );

    modport slave (
        input  start, opcode, operand_a, operand_b,
        output result, ALU_flags, ALU_ready, busy
    );

endinterface

// File: rtl/alu_multicycle_muldiv_core.sv
// Iterative datapath: shift-add multiply and restoring divide run side by side,
// one bit per step; the owner picks the product, quotient or remainder.
module alu_multicycle_muldiv_core
    import alu_multicycle_pkg::*;
#(
    parameter int W = WIDTH,
    parameter int N = ITER_CNT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o,
    output logic [W-1:0]   quotient_o,
    output logic [W-1:0]   remainder_o
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   divisor_q;

    logic [W:0] shifted_d;
    logic [W:0] trial_d;

    // Restoring step: a clear top bit of the trial means the divisor fitted.
    assign shifted_d = {rem_q, quo_q[W-1]};
    assign trial_d   = shifted_d - {1'b0, divisor_q};

    assign done_o      = (cnt_q == CW'(N));
    assign product_o   = acc_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
        end else if (load_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= {{W{1'b0}}, a_i};
            mplier_q  <= b_i;
            rem_q     <= '0;
            quo_q     <= a_i;
            divisor_q <= b_i;
        end else if (step_i && !done_o) begin
            cnt_q    <= cnt_q + CW'(1);
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (!trial_d[W]) begin
                rem_q <= trial_d[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted_d[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// 16-bit multi-cycle ALU: controller FSM, single-cycle ops, flag generation and
// registered outputs; MUL/DIV/MOD are delegated to the iterative core.
module alu_multicycle
    import alu_multicycle_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    alu_multicycle_if.slave  bus
);

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             ready_q;
    logic             busy_q;

    logic               coreLoad;
    logic               coreDone;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               iterReq;

    logic [WIDTH:0]   sum17;
    logic [WIDTH:0]   diff17;
    logic [WIDTH-1:0] execRes;
    logic             execC;
    logic             execV;
    logic [WIDTH-1:0] iterRes;
    logic             iterC;

    // MUL always iterates; DIV/MOD by zero take the one-cycle error path.
    assign iterReq  = (bus.opcode == OP_MUL) ||
                      (((bus.opcode == OP_DIV) || (bus.opcode == OP_MOD)) && (bus.operand_b != '0));
    assign coreLoad = (state_q == S_IDLE) && bus.start && iterReq;

    alu_multicycle_muldiv_core #(.W(WIDTH), .N(ITER_CNT)) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (coreLoad),
        .step_i      (state_q == S_ITER),
        .a_i         (bus.operand_a),
        .b_i         (bus.operand_b),
        .done_o      (coreDone),
        .product_o   (product),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    assign sum17  = {1'b0, a_q} + {1'b0, b_q};
    assign diff17 = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        execRes = '0;
        execC   = 1'b0;
        execV   = 1'b0;
        case (op_q)
            OP_ADD: begin
                execRes = sum17[WIDTH-1:0];
                execC   = sum17[WIDTH];
                execV   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (execRes[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                execRes = diff17[WIDTH-1:0];
                execC   = diff17[WIDTH];
                execV   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (execRes[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: execRes = a_q & b_q;
            OP_OR:  execRes = a_q | b_q;
            OP_XOR: execRes = a_q ^ b_q;
            OP_NOT: execRes = ~a_q;
            OP_SHL: begin
                execRes = {a_q[WIDTH-2:0], 1'b0};
                execC   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                execRes = {1'b0, a_q[WIDTH-1:1]};
                execC   = a_q[0];
            end
            OP_DIV, OP_MOD: begin
                execRes = '1;
                execV   = 1'b1;
            end
            default: begin
                execRes = '0;
                execV   = 1'b1;
            end
        endcase
    end

    always_comb begin
        iterRes = product[WIDTH-1:0];
        iterC   = 1'b0;
        case (op_q)
            OP_DIV:  iterRes = quotient;
            OP_MOD:  iterRes = remainder;
            default: iterC   = |product[2*WIDTH-1:WIDTH];
        endcase
    end

    // Outputs change only when entering DONE, so they hold through ITER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.start) begin
                        op_q    <= bus.opcode;
                        a_q     <= bus.operand_a;
                        b_q     <= bus.operand_b;
                        busy_q  <= 1'b1;
                        state_q <= iterReq ? S_ITER : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q <= execRes;
                    flags_q  <= makeFlags(execRes, execC, execV);
                    ready_q  <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_ITER: begin
                    if (coreDone) begin
                        result_q <= iterRes;
                        flags_q  <= makeFlags(iterRes, iterC, 1'b0);
                        ready_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.ALU_flags = flags_q;
    assign bus.ALU_ready = ready_q;
    assign bus.busy      = busy_q;

endmodule
